// File: rtl/sr_ff_exerciser.sv
// -----------------------------------------------------------------------------
// sr_ff_exerciser
//
// Stimulus generator and response checker for SR flip-flops. A run starts
// with a reset vector (S=0, R=1) that forces a known Q=0, then applies
// NUM_STEPS pseudo-random S/R vectors taken from an 8-bit LFSR. Each vector is
// held for HOLD_CYCLES clocks. On the last clock of each vector the reference
// model of Q is updated and, whenever the model value is known, Q/Q_bar from
// the flip-flop under test are compared against it.
//
// Ports
//   clk        in   single rising-edge clock
//   reset      in   asynchronous, active-low reset
//   start      in   one-cycle pulse that begins a run; ignored while busy/done
//   q, q_bar   in   outputs of the flip-flop under test
//   s, r       out  registered S/R drive to the flip-flop under test
//   busy       out  high from the cycle after start through the final sample
//   done       out  one-cycle pulse after the final sample
//   pass       out  set at done when no mismatch was seen; cleared on start
//   err_count  out  mismatching samples in the current run (saturating)
//   chk_count  out  samples actually compared in the current run (saturating)
// -----------------------------------------------------------------------------
module sr_ff_exerciser #(
    parameter int unsigned NUM_STEPS   = 16,
    parameter int unsigned HOLD_CYCLES = 2,
    parameter logic [7:0]  SEED        = 8'hA5,
    parameter int unsigned ERR_W       = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             q,
    input  logic             q_bar,
    output logic             s,
    output logic             r,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [ERR_W-1:0] chk_count
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_INIT,
        ST_DRIVE,
        ST_DONE
    } state_t;

    localparam int unsigned HCW       = $clog2(HOLD_CYCLES);
    localparam logic [HCW-1:0] HOLD_LAST = HCW'(HOLD_CYCLES - 1);
    localparam logic [7:0] STEP_LAST  = 8'(NUM_STEPS);
    // An all-zero LFSR would lock up, so a zero seed is promoted to 1.
    localparam logic [7:0] SEED_EFF   = (SEED == 8'h00) ? 8'h01 : SEED;

    // Registered state
    state_t           r_state;
    logic [7:0]       r_lfsr;
    logic             r_q_exp;
    logic             r_known;
    logic [7:0]       r_step;
    logic [HCW-1:0]   r_hold_cnt;
    logic             r_s;
    logic             r_r;
    logic             r_busy;
    logic             r_done;
    logic             r_pass;
    logic [ERR_W-1:0] r_err;
    logic [ERR_W-1:0] r_chk;

    // Next-state values
    state_t           w_state;
    logic [7:0]       w_lfsr;
    logic             w_q_exp;
    logic             w_known;
    logic [7:0]       w_step;
    logic [HCW-1:0]   w_hold_cnt;
    logic             w_s;
    logic             w_r;
    logic             w_busy;
    logic             w_done;
    logic             w_pass;
    logic [ERR_W-1:0] w_err;
    logic [ERR_W-1:0] w_chk;

    // Helpers
    logic [7:0]       w_lfsr_next;
    logic             w_last;
    logic             w_q_exp_upd;
    logic             w_known_upd;
    logic             w_mis;
    logic             w_final;
    logic [ERR_W-1:0] w_err_after;
    logic [ERR_W-1:0] w_chk_after;

    // x^8 + x^6 + x^5 + x^4 + 1, shifting left with feedback into bit 0.
    assign w_lfsr_next = {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
    assign w_last      = (r_hold_cnt == HOLD_LAST);

    // Reference model update for the vector currently being held. INIT always
    // establishes Q=0; afterwards the SR truth table applies, with S=R=1
    // leaving the model undefined until the next set or reset.
    always_comb begin
        w_q_exp_upd = r_q_exp;
        w_known_upd = r_known;
        if (r_state == ST_INIT) begin
            w_q_exp_upd = 1'b0;
            w_known_upd = 1'b1;
        end else begin
            unique case ({r_s, r_r})
                2'b10:   begin w_q_exp_upd = 1'b1; w_known_upd = 1'b1; end
                2'b01:   begin w_q_exp_upd = 1'b0; w_known_upd = 1'b1; end
                2'b11:   w_known_upd = 1'b0;
                default: ;
            endcase
        end
    end

    // One error per sample, whether Q, Q_bar or both are wrong.
    assign w_mis = (q != w_q_exp_upd) || (q_bar != ~w_q_exp_upd);

    // Counters as they will stand after this cycle's sample (only meaningful
    // on the last hold cycle); both saturate at all-ones.
    always_comb begin
        w_chk_after = r_chk;
        w_err_after = r_err;
        if (w_known_upd) begin
            if (r_chk != '1) w_chk_after = r_chk + 1'b1;
            if (w_mis && (r_err != '1)) w_err_after = r_err + 1'b1;
        end
    end

    // The INIT step is final only when no random steps were requested.
    assign w_final = (r_state == ST_INIT) ? (NUM_STEPS == 0) : (r_step == STEP_LAST);

    // NOTE: every signal gets its hold value before the case statement, so no
    // path through this block can leave a signal unassigned and infer a latch.
    always_comb begin
        w_state    = r_state;
        w_lfsr     = r_lfsr;
        w_q_exp    = r_q_exp;
        w_known    = r_known;
        w_step     = r_step;
        w_hold_cnt = r_hold_cnt;
        w_s        = r_s;
        w_r        = r_r;
        w_busy     = r_busy;
        w_done     = 1'b0;
        w_pass     = r_pass;
        w_err      = r_err;
        w_chk      = r_chk;

        unique case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state    = ST_INIT;
                    w_s        = 1'b0;
                    w_r        = 1'b1;
                    w_busy     = 1'b1;
                    w_pass     = 1'b0;
                    w_err      = '0;
                    w_chk      = '0;
                    w_lfsr     = SEED_EFF;
                    w_step     = 8'd0;
                    w_hold_cnt = '0;
                end
            end

            ST_INIT, ST_DRIVE: begin
                if (w_last) begin
                    w_q_exp = w_q_exp_upd;
                    w_known = w_known_upd;
                    w_chk   = w_chk_after;
                    w_err   = w_err_after;
                    if (w_final) begin
                        w_state = ST_DONE;
                        w_busy  = 1'b0;
                        w_done  = 1'b1;
                        w_pass  = (w_err_after == '0);
                        w_s     = 1'b0;
                        w_r     = 1'b0;
                    end else begin
                        w_state    = ST_DRIVE;
                        w_lfsr     = w_lfsr_next;
                        w_s        = w_lfsr_next[0];
                        w_r        = w_lfsr_next[1];
                        w_step     = r_step + 8'd1;
                        w_hold_cnt = '0;
                    end
                end else begin
                    w_hold_cnt = r_hold_cnt + 1'b1;
                end
            end

            ST_DONE: begin
                // start is deliberately not examined here.
                w_state = ST_IDLE;
            end

            default: w_state = ST_IDLE;
        endcase
    end

    // NOTE: state updates use non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    // NOTE: every register, including the model and LFSR, is reset; an
    // aborted run must leave nothing behind that could leak into the next one.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_lfsr     <= SEED_EFF;
            r_q_exp    <= 1'b0;
            r_known    <= 1'b0;
            r_step     <= 8'd0;
            r_hold_cnt <= '0;
            r_s        <= 1'b0;
            r_r        <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_pass     <= 1'b0;
            r_err      <= '0;
            r_chk      <= '0;
        end else begin
            r_state    <= w_state;
            r_lfsr     <= w_lfsr;
            r_q_exp    <= w_q_exp;
            r_known    <= w_known;
            r_step     <= w_step;
            r_hold_cnt <= w_hold_cnt;
            r_s        <= w_s;
            r_r        <= w_r;
            r_busy     <= w_busy;
            r_done     <= w_done;
            r_pass     <= w_pass;
            r_err      <= w_err;
            r_chk      <= w_chk;
        end
    end

    assign s         = r_s;
    assign r         = r_r;
    assign busy      = r_busy;
    assign done      = r_done;
    assign pass      = r_pass;
    assign err_count = r_err;
    assign chk_count = r_chk;

endmodule

// File: tb/tb_sr_ff_exerciser.sv
// -----------------------------------------------------------------------------
// tb_sr_ff_exerciser
//
// Four exerciser instances, each driving a behavioural SR flip-flop:
//   0: default parameters; its Q/Q_bar can be faulted (stuck-at-0, Q_bar=Q)
//   1: SEED=0 (must behave like SEED=1)
//   2: NUM_STEPS=0, HOLD_CYCLES=3 (INIT step only)
//   3: NUM_STEPS=40, ERR_W=4 with Q_bar tied to Q (counter saturation)
// Expected S/R sequences and counts come from a step-level model of the run.
// -----------------------------------------------------------------------------
module tb_sr_ff_exerciser;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic start_a [4];
    logic s_a     [4];
    logic r_a     [4];
    logic busy_a  [4];
    logic done_a  [4];
    logic pass_a  [4];
    logic q_a     [4];
    logic qb_a    [4];
    logic gq      [4];

    logic [7:0] err0, chk0, err1, chk1, err2, chk2;
    logic [3:0] err3, chk3;

    int mode0;   // 0 golden, 1 Q stuck at 0, 2 Q_bar tied to Q
    int total = 0;
    int bad   = 0;

    logic [1:0] exp_sr[$];   // expected {s,r} per step, step 0 is INIT

    // Behavioural synchronous SR flip-flops (S=R=1 resolves to 0 here; the
    // exerciser never checks that case).
    always @(posedge clk or negedge rst_n) begin
        for (int i = 0; i < 4; i++) begin
            if (!rst_n) gq[i] <= 1'b0;
            else begin
                case ({s_a[i], r_a[i]})
                    2'b10:   gq[i] <= 1'b1;
                    2'b01:   gq[i] <= 1'b0;
                    2'b11:   gq[i] <= 1'b0;
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        q_a[0]  = (mode0 == 1) ? 1'b0 : gq[0];
        qb_a[0] = (mode0 == 2) ? q_a[0] : ~gq[0];
        q_a[1]  = gq[1];
        qb_a[1] = ~gq[1];
        q_a[2]  = gq[2];
        qb_a[2] = ~gq[2];
        q_a[3]  = gq[3];
        qb_a[3] = gq[3];
    end

    sr_ff_exerciser dut0 (
        .clk(clk), .reset(rst_n), .start(start_a[0]), .q(q_a[0]), .q_bar(qb_a[0]),
        .s(s_a[0]), .r(r_a[0]), .busy(busy_a[0]), .done(done_a[0]), .pass(pass_a[0]),
        .err_count(err0), .chk_count(chk0)
    );

    sr_ff_exerciser #(.SEED(8'h00)) dut1 (
        .clk(clk), .reset(rst_n), .start(start_a[1]), .q(q_a[1]), .q_bar(qb_a[1]),
        .s(s_a[1]), .r(r_a[1]), .busy(busy_a[1]), .done(done_a[1]), .pass(pass_a[1]),
        .err_count(err1), .chk_count(chk1)
    );

    sr_ff_exerciser #(.NUM_STEPS(0), .HOLD_CYCLES(3)) dut2 (
        .clk(clk), .reset(rst_n), .start(start_a[2]), .q(q_a[2]), .q_bar(qb_a[2]),
        .s(s_a[2]), .r(r_a[2]), .busy(busy_a[2]), .done(done_a[2]), .pass(pass_a[2]),
        .err_count(err2), .chk_count(chk2)
    );

    sr_ff_exerciser #(.NUM_STEPS(40), .ERR_W(4)) dut3 (
        .clk(clk), .reset(rst_n), .start(start_a[3]), .q(q_a[3]), .q_bar(qb_a[3]),
        .s(s_a[3]), .r(r_a[3]), .busy(busy_a[3]), .done(done_a[3]), .pass(pass_a[3]),
        .err_count(err3), .chk_count(chk3)
    );

    function automatic logic [31:0] get_err(int idx);
        case (idx)
            0:       return 32'(err0);
            1:       return 32'(err1);
            2:       return 32'(err2);
            default: return 32'(err3);
        endcase
    endfunction

    function automatic logic [31:0] get_chk(int idx);
        case (idx)
            0:       return 32'(chk0);
            1:       return 32'(chk1);
            2:       return 32'(chk2);
            default: return 32'(chk3);
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] lfsr_adv(logic [7:0] x);
        return {x[6:0], x[7] ^ x[5] ^ x[4] ^ x[3]};
    endfunction

    // Step-level model: builds the expected vector list and the final counts.
    task automatic model(input logic [7:0] seed, input int n, input int mode,
                         output int chk, output int err);
        logic [7:0] l;
        bit qe, kn;
        exp_sr.delete();
        l = (seed == 8'h00) ? 8'h01 : seed;
        exp_sr.push_back(2'b01);
        qe  = 1'b0;
        kn  = 1'b1;
        chk = 1;
        err = (mode == 2) ? 1 : 0;
        for (int j = 1; j <= n; j++) begin
            l = lfsr_adv(l);
            exp_sr.push_back({l[0], l[1]});
            case ({l[0], l[1]})
                2'b10: begin qe = 1'b1; kn = 1'b1; end
                2'b01: begin qe = 1'b0; kn = 1'b1; end
                2'b11: kn = 1'b0;
                default: ;
            endcase
            if (kn) begin
                chk++;
                if (mode == 2 || (mode == 1 && qe)) err++;
            end
        end
    endtask

    task automatic run(input int idx, input int n, input int h, input logic [7:0] seed,
                       input int mode, input int emax, input bit hold_start, input string tag);
        int exp_chk, exp_err, cyc, mism, done_seen, late;
        logic [1:0] got[$];
        logic [7:0] l1;
        model(seed, n, mode, exp_chk, exp_err);
        if (exp_err > emax) exp_err = emax;
        if (exp_chk > emax) exp_chk = emax;

        repeat ($urandom_range(1, 4)) @(negedge clk);
        start_a[idx] = 1'b1;
        @(negedge clk);
        if (!hold_start) start_a[idx] = 1'b0;
        check({tag, "/pass_cleared"}, 32'(pass_a[idx]), 0);

        cyc = 0;
        done_seen = 0;
        while (busy_a[idx] === 1'b1 && cyc < 5000) begin
            got.push_back({s_a[idx], r_a[idx]});
            if (done_a[idx] !== 1'b0) done_seen++;
            cyc++;
            // Stray start pulses during the run must be ignored.
            if (!hold_start) start_a[idx] = ($urandom_range(0, 7) == 0);
            @(negedge clk);
        end
        start_a[idx] = hold_start ? 1'b1 : 1'(($urandom_range(0, 1)));

        check({tag, "/busy_len"}, cyc, (n + 1) * h);
        check({tag, "/done_in_busy"}, done_seen, 0);
        check({tag, "/done"}, 32'(done_a[idx]), 1);
        check({tag, "/sr_idle"}, 32'({s_a[idx], r_a[idx]}), 0);
        check({tag, "/err_count"}, get_err(idx), exp_err);
        check({tag, "/chk_count"}, get_chk(idx), exp_chk);
        check({tag, "/pass"}, 32'(pass_a[idx]), (exp_err == 0) ? 1 : 0);

        mism = 0;
        for (int c = 0; c < got.size(); c++) begin
            if (c / h >= exp_sr.size() || got[c] !== exp_sr[c / h]) mism++;
        end
        check({tag, "/sr_seq"}, mism, 0);
        if (n >= 1 && got.size() > h) begin
            l1 = lfsr_adv((seed == 8'h00) ? 8'h01 : seed);
            check({tag, "/first_vec"}, 32'(got[h]), 32'({l1[0], l1[1]}));
        end

        @(negedge clk);
        start_a[idx] = 1'b0;
        check({tag, "/done_pulse_end"}, 32'(done_a[idx]), 0);
        late = 0;
        repeat (3) begin
            if (busy_a[idx] !== 1'b0) late++;
            @(negedge clk);
        end
        check({tag, "/single_run"}, late, 0);
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int spur;
        rst_n = 1'b0;
        mode0 = 0;
        for (int i = 0; i < 4; i++) start_a[i] = 1'b0;
        repeat (2) @(negedge clk);

        check("reset/s", 32'(s_a[0]), 0);
        check("reset/r", 32'(r_a[0]), 0);
        check("reset/busy", 32'(busy_a[0]), 0);
        check("reset/done", 32'(done_a[0]), 0);
        check("reset/pass", 32'(pass_a[0]), 0);
        check("reset/err", get_err(0), 0);
        check("reset/chk", get_chk(0), 0);

        rst_n = 1'b1;
        @(negedge clk);

        run(0, 16, 2, 8'hA5, 0, 255, 1'b0, "golden");
        mode0 = 1;
        run(0, 16, 2, 8'hA5, 1, 255, 1'b0, "q_stuck0");
        mode0 = 2;
        run(0, 16, 2, 8'hA5, 2, 255, 1'b0, "qbar_eq_q");

        // Abort a faulted run at its tenth busy cycle.
        start_a[0] = 1'b1;
        @(negedge clk);
        start_a[0] = 1'b0;
        repeat (9) @(negedge clk);
        check("abort/busy_before", 32'(busy_a[0]), 1);
        check("abort/err_nonzero", 32'(get_err(0) != 0), 1);
        #2 rst_n = 1'b0;
        #1;
        check("abort/s", 32'(s_a[0]), 0);
        check("abort/r", 32'(r_a[0]), 0);
        check("abort/busy", 32'(busy_a[0]), 0);
        check("abort/err", get_err(0), 0);
        check("abort/chk", get_chk(0), 0);
        spur = 0;
        repeat (2) begin
            @(negedge clk);
            if (done_a[0] !== 1'b0 || busy_a[0] !== 1'b0) spur++;
        end
        rst_n = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (done_a[0] !== 1'b0 || busy_a[0] !== 1'b0) spur++;
        end
        check("abort/no_done", spur, 0);

        mode0 = 0;
        run(0, 16, 2, 8'hA5, 0, 255, 1'b0, "after_abort");
        run(0, 16, 2, 8'hA5, 0, 255, 1'b1, "start_held");
        run(1, 16, 2, 8'h00, 0, 255, 1'b0, "seed0");
        run(2, 0, 3, 8'hA5, 0, 255, 1'b0, "nsteps0");
        run(3, 40, 2, 8'hA5, 2, 15, 1'b0, "saturate");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
